// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scanning driver: logical segment
// patterns ({g,f,e,d,c,b,a}, 1 = lit), scan FSM states and a width helper.
package seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int width_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to logical seven-segment pattern decoder (1 = lit).
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] pattern_o
);

    always_comb begin
        pattern_o = SEG_OFF;
        unique case (nibble_i)
            4'h0: pattern_o = SEG_0;
            4'h1: pattern_o = SEG_1;
            4'h2: pattern_o = SEG_2;
            4'h3: pattern_o = SEG_3;
            4'h4: pattern_o = SEG_4;
            4'h5: pattern_o = SEG_5;
            4'h6: pattern_o = SEG_6;
            4'h7: pattern_o = SEG_7;
            4'h8: pattern_o = SEG_8;
            4'h9: pattern_o = SEG_9;
            4'hA: pattern_o = SEG_A;
            4'hB: pattern_o = SEG_B;
            4'hC: pattern_o = SEG_C;
            4'hD: pattern_o = SEG_D;
            4'hE: pattern_o = SEG_E;
            4'hF: pattern_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg_disp_mux.sv
// Time-multiplexed seven-segment driver: shadowed inputs, BLANK/SHOW scan FSM,
// digit masking, leading-zero suppression and registered polarity-adjusted outputs.
module seg_disp_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [4*NUM_DIGITS-1:0]            value,
    input  logic [NUM_DIGITS-1:0]              dp_in,
    input  logic [NUM_DIGITS-1:0]              digit_en,
    input  logic                               lz_en,
    input  logic                               load,
    output logic [NUM_DIGITS-1:0]              an,
    output logic [6:0]                         seg,
    output logic                               dp,
    output logic [width_for(NUM_DIGITS)-1:0]   digit_idx
);

    localparam int IDX_W   = width_for(NUM_DIGITS);
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = width_for(CNT_MAX);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] sh_value_q;
    logic [NUM_DIGITS-1:0]   sh_dp_q;
    logic [NUM_DIGITS-1:0]   sh_en_q;
    logic                    sh_lz_q;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [6:0]              cap_seg_q, cap_seg_d;
    logic                    cap_dp_q, cap_dp_d;
    logic                    cap_lit_q, cap_lit_d;

    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    out_dp_q, out_dp_d;
    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;

    logic [NUM_DIGITS-1:0]   lit_mask;
    logic [3:0]              nib_sel;
    logic                    dp_sel;
    logic                    lit_sel;
    logic [6:0]              pattern;
    logic                    show_lit;

    // A digit may light if enabled and not part of the run of leading zeros;
    // a requested decimal point ends that run at its own digit.
    always_comb begin
        logic run_zero;
        run_zero = 1'b1;
        lit_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run_zero    = run_zero && (sh_value_q[k*4 +: 4] == 4'h0) && !sh_dp_q[k];
            lit_mask[k] = sh_en_q[k] && !(sh_lz_q && run_zero);
        end
        lit_mask[0] = sh_en_q[0];
    end

    always_comb begin
        nib_sel = 4'h0;
        dp_sel  = 1'b0;
        lit_sel = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib_sel = sh_value_q[k*4 +: 4];
                dp_sel  = sh_dp_q[k];
                lit_sel = lit_mask[k];
            end
        end
    end

    hex7seg u_hex7seg (
        .nibble_i  (nib_sel),
        .pattern_o (pattern)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        cap_seg_d = cap_seg_q;
        cap_dp_d  = cap_dp_q;
        cap_lit_d = cap_lit_q;
        unique case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d   = SHOW;
                    cnt_d     = '0;
                    cap_seg_d = pattern;
                    cap_dp_d  = dp_sel;
                    cap_lit_d = lit_sel;
                end
            end
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
        endcase
    end

    // Outputs are derived from the registered state, so they trail it by one cycle.
    assign show_lit = (state_q == SHOW) && cap_lit_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
            assign an_d[gi] = (show_lit && (idx_q == IDX_W'(gi))) ^ ACTIVE_LOW;
        end
    endgenerate

    assign seg_d       = (show_lit ? cap_seg_q : SEG_OFF) ^ {7{ACTIVE_LOW}};
    assign out_dp_d    = (show_lit && cap_dp_q) ^ ACTIVE_LOW;
    assign digit_idx_d = (state_q == SHOW) ? idx_q : digit_idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_value_q  <= '0;
            sh_dp_q     <= '0;
            sh_en_q     <= '1;
            sh_lz_q     <= 1'b0;
            state_q     <= BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            cap_seg_q   <= SEG_OFF;
            cap_dp_q    <= 1'b0;
            cap_lit_q   <= 1'b0;
            an_q        <= {NUM_DIGITS{ACTIVE_LOW}};
            seg_q       <= {7{ACTIVE_LOW}};
            out_dp_q    <= ACTIVE_LOW;
            digit_idx_q <= '0;
        end else begin
            if (load) begin
                sh_value_q <= value;
                sh_dp_q    <= dp_in;
                sh_en_q    <= digit_en;
                sh_lz_q    <= lz_en;
            end
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            cap_seg_q   <= cap_seg_d;
            cap_dp_q    <= cap_dp_d;
            cap_lit_q   <= cap_lit_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            out_dp_q    <= out_dp_d;
            digit_idx_q <= digit_idx_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = out_dp_q;
    assign digit_idx = digit_idx_q;

endmodule

// File: tb/tb_seg_disp_mux.sv
// Directed bench for seg_disp_mux: 4-digit active-low scan plus a 1-digit active-high instance.
module tb_seg_disp_mux;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, load, lz_en;
    logic [15:0] value;
    logic [3:0]  dp_in, digit_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;

    logic        rst2, load2, lz2;
    logic [3:0]  value2;
    logic [0:0]  dp_in2, en2, an2, digit_idx2;
    logic [6:0]  seg2;
    logic        dp2;

    int checks = 0;
    int passes = 0;

    seg_disp_mux #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .digit_en(digit_en),
        .lz_en(lz_en), .load(load), .an(an), .seg(seg), .dp(dp), .digit_idx(digit_idx)
    );

    seg_disp_mux #(
        .NUM_DIGITS(1), .REFRESH_DIV(4), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b0)
    ) dut_pol (
        .clk(clk), .rst(rst2), .value(value2), .dp_in(dp_in2), .digit_en(en2),
        .lz_en(lz2), .load(load2), .an(an2), .seg(seg2), .dp(dp2), .digit_idx(digit_idx2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One 24-cycle frame starting right after a frame boundary. segs holds the
    // logical pattern per digit {d3,d2,d1,d0}; an optional load fires before edge load_cyc.
    task automatic run_frame(input string tag, input logic [27:0] segs, input logic [3:0] lits,
                             input logic [3:0] dps, input int load_cyc, input logic [15:0] load_val);
        for (int c = 1; c <= 24; c++) begin
            int j, p;
            logic lit;
            logic [3:0] exp_an;
            logic [6:0] exp_seg;
            logic exp_dp;
            if (c == load_cyc) begin
                value = load_val;
                load  = 1'b1;
            end
            @(posedge clk);
            #1;
            load = 1'b0;
            j = (c - 1) / 6;
            p = (c - 1) % 6;
            lit = (p >= 2) && lits[j];
            exp_an = 4'hF;
            if (lit) exp_an[j] = 1'b0;
            exp_seg = lit ? ~segs[j*7 +: 7] : 7'h7F;
            exp_dp  = lit ? ~dps[j] : 1'b1;
            check($sformatf("%s_an c%0d", tag, c), 32'(an), 32'(exp_an));
            check($sformatf("%s_seg c%0d", tag, c), 32'(seg), 32'(exp_seg));
            check($sformatf("%s_dp c%0d", tag, c), 32'(dp), 32'(exp_dp));
            if (p >= 2) check($sformatf("%s_idx c%0d", tag, c), 32'(digit_idx), 32'(j));
        end
        $display("frame %s done: %0d/%0d so far", tag, passes, checks);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; digit_en = 4'hF; lz_en = 1'b0;
        rst2 = 1'b1; load2 = 1'b0; value2 = '0; dp_in2 = '0; en2 = 1'b1; lz2 = 1'b0;
        #12;
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_idx", 32'(digit_idx), 32'h0);
        check("rst_pol_an", 32'(an2), 32'h0);
        check("rst_pol_seg", 32'(seg2), 32'h00);
        check("rst_pol_dp", 32'(dp2), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // F, A, 2, 1 on digits 0..3
        run_frame("scan", {7'h06, 7'h5B, 7'h77, 7'h71}, 4'hF, 4'h0, 1, 16'h12AF);
        run_frame("scan2", {7'h06, 7'h5B, 7'h77, 7'h71}, 4'hF, 4'h0, 0, 16'h0);
        digit_en = 4'b0101;
        run_frame("mask", {7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0101, 4'h0, 1, 16'h12AF);
        digit_en = 4'hF;
        lz_en = 1'b1;
        run_frame("lz", {7'h3F, 7'h3F, 7'h4F, 7'h3F}, 4'b0011, 4'h0, 1, 16'h0030);
        dp_in = 4'b0100;
        run_frame("lzdp", {7'h3F, 7'h3F, 7'h4F, 7'h3F}, 4'b0111, 4'b0100, 1, 16'h0030);
        dp_in = 4'b0000;
        run_frame("lz0", {4{7'h3F}}, 4'b0001, 4'h0, 1, 16'h0000);
        lz_en = 1'b0;
        run_frame("pre", {4{7'h06}}, 4'hF, 4'h0, 1, 16'h1111);
        // load lands mid-way through digit 1's lit slot
        run_frame("midload", {7'h5B, 7'h5B, 7'h06, 7'h06}, 4'hF, 4'h0, 10, 16'h2222);
        // load on the same edge as digit 0's capture: digit 0 keeps the old "2"
        run_frame("edgeload", {7'h4F, 7'h4F, 7'h4F, 7'h5B}, 4'hF, 4'h0, 2, 16'h3333);

        repeat (4) @(posedge clk);
        #1;
        check("premid_an", 32'(an), 32'hE);
        #2;
        rst = 1'b1;
        #1;
        check("async_an", 32'(an), 32'hF);
        check("async_seg", 32'(seg), 32'h7F);
        check("async_dp", 32'(dp), 32'h1);
        check("async_idx", 32'(digit_idx), 32'h0);
        @(posedge clk); #1;
        check("rsthold_an", 32'(an), 32'hF);
        rst = 1'b0;
        run_frame("postrst", {4{7'h3F}}, 4'hF, 4'h0, 0, 16'h0);

        value2 = 4'h8;
        load2  = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            logic lit;
            @(posedge clk);
            #1;
            load2 = 1'b0;
            lit = ((c - 1) % 6) >= 2;
            check($sformatf("pol_an c%0d", c), 32'(an2), 32'(lit));
            check($sformatf("pol_seg c%0d", c), 32'(seg2), lit ? 32'h7F : 32'h00);
            check($sformatf("pol_dp c%0d", c), 32'(dp2), 32'h0);
        end
        $display("frame pol done: %0d/%0d so far", passes, checks);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seg_disp_mux.md
# seg_disp_mux

Parametrised, time-multiplexed seven-segment display driver for the board's common-anode digit bank. It replaces the fixed "force digits off" tie-off with a scanning driver for NUM_DIGITS digits, per-digit enable masking, decimal points, leading-zero suppression and an inter-digit blanking interval against ghosting. It sits between the CPU's display output register and the board anode/segment pins.

## Interface
- NUM_DIGITS, 4: digits scanned, 1..8
- REFRESH_DIV, 50000: clk cycles each digit is lit per slot, ≥1
- BLANK_CYCLES, 500: clk cycles all anodes are off between slots, ≥1
- ACTIVE_LOW, 1: 1 = anodes, segments and dp light with 0 and turn off with 1; 0 = inverted sense

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- value  in  4*NUM_DIGITS  hex nibbles, digit 0 = bits [3:0] (rightmost)
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
- digit_en  in  NUM_DIGITS  1 = digit may light; 0 = digit forced off
- lz_en  in  1  1 = blank leading zero digits
- load  in  1  single-cycle strobe; latches value/dp_in/digit_en/lz_en into shadow
- an  out  NUM_DIGITS  digit anodes
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp  out  1  decimal point segment
- digit_idx  out  clog2(NUM_DIGITS), min 1  index of the current or most recent slot

## Operation
- Shadow registers are written on a clk edge where load=1. Reset clears value, dp and lz_en shadows to 0 and sets the digit_en shadow to all 1s.
- Two-state FSM, BLANK and SHOW, with a cycle counter and digit index idx.
- BLANK: all anodes off and seg/dp off. After BLANK_CYCLES cycles, go to SHOW. On this transition, capture the pattern for digit idx from the shadow.
- SHOW: only an[idx] is active, with the captured seg/dp. After REFRESH_DIV cycles, go to BLANK and advance idx. idx wraps from NUM_DIGITS-1 to 0.
- The captured pattern is frozen for the whole slot. A load mid-slot affects only the next slot.
- Disabled digit (digit_en shadow bit = 0): the slot still takes REFRESH_DIV cycles, so the refresh rate stays constant. Its anode, seg and dp stay off.
- Leading-zero suppression (lz_en=1):
  - A digit k>0 is blanked (anode off) when nibble k and every higher nibble are 0.
  - Digit 0 is never suppressed.
  - A set dp bit on digit k stops suppression at digit k and at every lower digit.
- Hex decode covers all 16 codes: 0–9, then A, b, C, d, E, F. The logical pattern for "0" is a–f on.
- Polarity: the logical lit=1 value is XORed with ACTIVE_LOW at the output registers.
- Reset is asynchronous, including mid-slot:
  - state=BLANK, counter=0, idx=0;
  - all an, seg and dp at the off level (all 1s when ACTIVE_LOW=1);
  - digit_idx=0.

## Timing
- an, seg, dp and digit_idx are registered and change only on the rising edge of clk.
- Outputs follow the state register with 1 cycle latency.
- Each digit is lit for exactly REFRESH_DIV consecutive cycles. It is followed by exactly BLANK_CYCLES cycles with all anodes off.
- One full frame lasts NUM_DIGITS*(REFRESH_DIV+BLANK_CYCLES) cycles.
- After rst is released, the first lit cycle of digit 0 is cycle BLANK_CYCLES+1.
- A load on the same edge as a BLANK→SHOW transition is not seen by that slot. The capture uses the old shadow.
- Counter width is clog2(max(REFRESH_DIV, BLANK_CYCLES)). The counter wraps to 0 at each state change.
- No two anodes are ever active in the same cycle. Any glitch or overlap is a bug.

## Structure
- Shared package seg_pkg holds:
  - the segment-pattern constants SEG_0..SEG_F and SEG_OFF;
  - the FSM state encoding (BLANK, SHOW).
- One sub-module, hex7seg: a purely combinational 4-bit nibble to 7-bit logical pattern decoder. It is instantiated once and fed by a mux on idx.
- Everything else lives in seg_disp_mux.

## Test plan
- Scan order, NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2, ACTIVE_LOW=1, value=16'h12AF, all enabled:
  - the an sequence repeats 1110, 1101, 1011, 0111, each held 4 cycles, with 1111 for 2 cycles between them;
  - seg shows F, A, 2, 1 in that order.
- Masking: digit_en=4'b0101 → digits 1 and 3 never drive an low. Their slots still last 4+2 cycles, and the frame is still 24 cycles.
- Leading zeros: value=16'h0030, lz_en=1 → only digits 0 and 1 light (0, then 3).
  - The same value with dp_in=4'b0100 also lights digit 2 as "0." with dp=0.
  - value=0 with lz_en=1 → only digit 0 lights, showing "0".
- Mid-slot load: load value 16'h1111 → 16'h2222 during digit 1's SHOW → digit 1 keeps the "1" pattern to the end of its slot, and digit 2 shows "2".
- Async reset: assert rst mid-SHOW, with no clk edge → an=1111, seg=7'h7F, dp=1 immediately.
  - After release, digit 0 is first lit at cycle BLANK_CYCLES+1.
- Polarity, ACTIVE_LOW=0, NUM_DIGITS=1 → an toggles 1 (lit) / 0 (blank), and seg for value "8" = 7'h7F.
